// File: rtl/bram_packet_ring_writer.sv
// bram_packet_ring_writer
// Buffers a valid/ready word stream in a small FIFO and writes it into a
// packet-aligned ring in the PS-visible capture BRAM. The write pointer
// seen by the PS only advances on whole-packet boundaries. The PS read
// pointer is respected unless overwrite mode is selected.
module bram_packet_ring_writer #(
    parameter int DATA_WIDTH       = 32,
    parameter int BRAM_ADDR_WIDTH  = 16,
    parameter int BRAM_DEPTH_WORDS = 16384,
    parameter int FIFO_DEPTH       = 256,
    parameter int PACKET_WORDS     = 144,
    localparam int PW = $clog2(BRAM_DEPTH_WORDS),
    localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       overwrite_en,
    input  logic                       clear,
    input  logic [PW-1:0]              rd_ptr,
    input  logic                       s_valid,
    input  logic [DATA_WIDTH-1:0]      s_data,
    output logic                       s_ready,
    output logic                       bram_clk,
    output logic                       bram_rst,
    output logic [BRAM_ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0]      bram_din,
    output logic                       bram_en,
    output logic [DATA_WIDTH/8-1:0]    bram_we,
    output logic [PW-1:0]              wr_ptr,
    output logic [CW-1:0]              fifo_count,
    output logic [31:0]                packet_count,
    output logic [31:0]                stall_cycles,
    output logic                       busy,
    output logic                       ptr_err
);

    localparam int BYTES      = DATA_WIDTH / 8;
    localparam int RING_WORDS = (BRAM_DEPTH_WORDS / PACKET_WORDS) * PACKET_WORDS;
    localparam int AW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int KW         = (PACKET_WORDS > 1) ? $clog2(PACKET_WORDS) : 1;

    // RING_SIZE carries one extra bit so a ring that fills the whole
    // pointer range still compares correctly against rd_ptr.
    localparam logic [PW-1:0]              RING_LAST = PW'(RING_WORDS - 1);
    localparam logic [PW:0]                RING_SIZE = (PW + 1)'(RING_WORDS);
    localparam logic [CW-1:0]              FIFO_FULL = CW'(FIFO_DEPTH);
    localparam logic [KW-1:0]              PKT_LAST  = KW'(PACKET_WORDS - 1);
    localparam logic [BRAM_ADDR_WIDTH-1:0] BYTE_STEP = BRAM_ADDR_WIDTH'(BYTES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]         fifo_head;
    logic [AW-1:0]         fifo_tail;
    logic                  fifo_empty;
    logic                  fifo_full;

    logic [PW-1:0]         wa;
    logic [PW-1:0]         wa_inc;
    logic [KW-1:0]         word_cnt;
    logic                  pkt_last;
    logic                  commit_pending;
    logic [PW-1:0]         commit_ptr;

    logic                  writer_active;
    logic                  ptr_bad;
    logic                  space_ok;
    logic                  push;
    logic                  pop;
    logic                  enter_idle;
    logic                  clear_now;

    assign bram_clk = clk;
    assign bram_rst = rst;
    assign busy     = (state != IDLE);

    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == FIFO_FULL);

    // Only RUN accepts new words; DRAIN just empties what is already queued.
    assign s_ready = (state == RUN) && !fifo_full;
    assign push    = s_valid && s_ready;

    // The ring keeps one slot free, so the writer may only advance while
    // the slot after wa is not the consumer's next read position.
    assign writer_active = (state == RUN) || (state == DRAIN);
    assign ptr_bad       = !overwrite_en && ({1'b0, rd_ptr} >= RING_SIZE);
    assign wa_inc        = (wa == RING_LAST) ? '0 : wa + PW'(1);
    assign space_ok      = overwrite_en || (wa_inc != rd_ptr);
    assign pop           = writer_active && !fifo_empty && space_ok && !ptr_bad;
    assign pkt_last      = (word_cnt == PKT_LAST);

    assign enter_idle = (state == DRAIN) && (state_next == IDLE);
    assign clear_now  = (state == IDLE) && clear;

    // State register for the enable/drain sequencing.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; DRAIN only finishes once nothing is queued or still
    // on its way into BRAM, including a pending packet commit.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (enable) begin
                    state_next = RUN;
                end else if (fifo_empty && !bram_en && !commit_pending) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // FIFO storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[fifo_tail] <= s_data;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop keep the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_head  <= '0;
            fifo_tail  <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                fifo_tail <= fifo_tail + AW'(1);
            end
            if (pop) begin
                fifo_head <= fifo_head + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Registered BRAM write port plus ring address and packet word tracking;
    // an unfinished packet is discarded by rewinding to the committed pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            bram_en        <= 1'b0;
            bram_we        <= '0;
            bram_addr      <= '0;
            bram_din       <= '0;
            wa             <= '0;
            word_cnt       <= '0;
            commit_pending <= 1'b0;
            commit_ptr     <= '0;
        end else begin
            bram_en        <= pop;
            bram_we        <= {BYTES{pop}};
            commit_pending <= 1'b0;
            if (pop) begin
                bram_addr <= BRAM_ADDR_WIDTH'(wa) * BYTE_STEP;
                bram_din  <= fifo_mem[fifo_head];
                wa        <= wa_inc;
                if (pkt_last) begin
                    word_cnt       <= '0;
                    commit_pending <= 1'b1;
                    commit_ptr     <= wa_inc;
                end else begin
                    word_cnt <= word_cnt + KW'(1);
                end
            end
            if (enter_idle) begin
                wa       <= wr_ptr;
                word_cnt <= '0;
            end else if (clear_now) begin
                wa       <= '0;
                word_cnt <= '0;
            end
        end
    end

    // Status bank: packet commits, saturating stall counter, sticky pointer error.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            packet_count <= '0;
            stall_cycles <= '0;
            ptr_err      <= 1'b0;
        end else begin
            if (commit_pending) begin
                wr_ptr       <= commit_ptr;
                packet_count <= packet_count + 32'd1;
            end
            if ((state == RUN) && s_valid && !s_ready && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (writer_active && ptr_bad) begin
                ptr_err <= 1'b1;
            end
            if (clear_now) begin
                wr_ptr       <= '0;
                packet_count <= '0;
                stall_cycles <= '0;
                ptr_err      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bram_packet_ring_writer.sv
// tb_bram_packet_ring_writer
// Drives directed scenarios into bram_packet_ring_writer and compares every
// cycle against a queue-based reference model, plus literal expectations.
module tb_bram_packet_ring_writer;

    localparam int DW    = 32;
    localparam int ADW   = 16;
    localparam int DEPTH = 16384;
    localparam int FD    = 256;
    localparam int PK    = 144;
    localparam int PW    = 14;
    localparam int CW    = 9;
    localparam int RING  = (DEPTH / PK) * PK;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            enable = 1'b0;
    logic            overwrite_en = 1'b0;
    logic            clear = 1'b0;
    logic [PW-1:0]   rd_ptr = '0;
    logic            s_valid = 1'b0;
    logic [DW-1:0]   s_data = '0;
    logic            s_ready;
    logic            bram_clk;
    logic            bram_rst;
    logic [ADW-1:0]  bram_addr;
    logic [DW-1:0]   bram_din;
    logic            bram_en;
    logic [DW/8-1:0] bram_we;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   fifo_count;
    logic [31:0]     packet_count;
    logic [31:0]     stall_cycles;
    logic            busy;
    logic            ptr_err;

    bram_packet_ring_writer #(
        .DATA_WIDTH      (DW),
        .BRAM_ADDR_WIDTH (ADW),
        .BRAM_DEPTH_WORDS(DEPTH),
        .FIFO_DEPTH      (FD),
        .PACKET_WORDS    (PK)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .overwrite_en(overwrite_en),
        .clear       (clear),
        .rd_ptr      (rd_ptr),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .bram_clk    (bram_clk),
        .bram_rst    (bram_rst),
        .bram_addr   (bram_addr),
        .bram_din    (bram_din),
        .bram_en     (bram_en),
        .bram_we     (bram_we),
        .wr_ptr      (wr_ptr),
        .fifo_count  (fifo_count),
        .packet_count(packet_count),
        .stall_cycles(stall_cycles),
        .busy        (busy),
        .ptr_err     (ptr_err)
    );

    always #5 clk = ~clk;

    // Reference model state: 0 idle, 1 running, 2 draining.
    int          m_state = 0;
    logic [31:0] m_q[$];
    int          m_wa = 0;
    int          m_wr_ptr = 0;
    int          m_inpkt = 0;
    logic [31:0] m_pkt = '0;
    logic [31:0] m_stall = '0;
    bit          m_perr = 1'b0;
    bit          m_en = 1'b0;
    int          m_addr = 0;
    logic [31:0] m_din = '0;
    bit          m_commit = 1'b0;
    int          m_commit_val = 0;
    bit          m_valid = 1'b0;

    int          tests = 0;
    int          fails = 0;
    string       lit_name = "";
    logic [63:0] lit_act = '0;
    logic [63:0] lit_exp = '0;
    int          lit_seq = 0;
    int          lit_done = 0;
    int          addr_log[$];
    logic [31:0] next_word = '0;

    // Reference model: advances one clock using the ring/packet rules on plain integers and a word queue.
    always @(posedge clk) begin : model_step
        bit rdy, push, pop, active, bad, space, was_en, was_commit;
        int qsize;
        if (rst) begin
            m_state = 0; m_q.delete(); m_wa = 0; m_wr_ptr = 0; m_inpkt = 0;
            m_pkt = '0; m_stall = '0; m_perr = 1'b0; m_en = 1'b0; m_addr = 0;
            m_din = '0; m_commit = 1'b0; m_commit_val = 0; m_valid = 1'b1;
        end else if (m_valid) begin
            qsize      = m_q.size();
            rdy        = (m_state == 1) && (qsize < FD);
            push       = s_valid && rdy;
            active     = (m_state != 0);
            bad        = !overwrite_en && (int'(rd_ptr) >= RING);
            space      = overwrite_en || (((m_wa + 1) % RING) != int'(rd_ptr));
            pop        = active && (qsize > 0) && space && !bad;
            was_en     = m_en;
            was_commit = m_commit;
            if (m_state == 1 && s_valid && !rdy && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
            if (active && bad) m_perr = 1'b1;
            if (was_commit) begin
                m_wr_ptr = m_commit_val;
                m_pkt    = m_pkt + 1;
                m_commit = 1'b0;
            end
            m_en = pop;
            if (pop) begin
                m_addr  = m_wa * (DW / 8);
                m_din   = m_q.pop_front();
                m_wa    = (m_wa + 1) % RING;
                m_inpkt = m_inpkt + 1;
                if (m_inpkt == PK) begin
                    m_inpkt      = 0;
                    m_commit     = 1'b1;
                    m_commit_val = m_wa;
                end
            end
            if (push) m_q.push_back(s_data);
            case (m_state)
                0: begin
                    if (clear) begin
                        m_wa = 0; m_wr_ptr = 0; m_inpkt = 0;
                        m_pkt = '0; m_stall = '0; m_perr = 1'b0;
                    end
                    if (enable) m_state = 1;
                end
                1: if (!enable) m_state = 2;
                default: begin
                    if (enable) m_state = 1;
                    else if (qsize == 0 && !was_en && !was_commit) begin
                        m_state = 0;
                        m_wa    = m_wr_ptr;
                        m_inpkt = 0;
                    end
                end
            endcase
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: literal expectations posted by the stimulus, then the model on every cycle.
    always @(negedge clk) begin
        if (lit_seq != lit_done) begin
            checkOutput(lit_name, lit_act, lit_exp);
            lit_done = lit_seq;
        end
        if (m_valid) begin
            checkOutput("s_ready", 64'(s_ready), 64'((m_state == 1) && (m_q.size() < FD)));
            checkOutput("bram_en", 64'(bram_en), 64'(m_en));
            checkOutput("bram_we", 64'(bram_we), m_en ? 64'hF : 64'h0);
            if (m_en) begin
                checkOutput("bram_addr", 64'(bram_addr), 64'(m_addr));
                checkOutput("bram_din", 64'(bram_din), 64'(m_din));
            end
            checkOutput("wr_ptr", 64'(wr_ptr), 64'(m_wr_ptr));
            checkOutput("fifo_count", 64'(fifo_count), 64'(m_q.size()));
            checkOutput("packet_count", 64'(packet_count), 64'(m_pkt));
            checkOutput("stall_cycles", 64'(stall_cycles), 64'(m_stall));
            checkOutput("busy", 64'(busy), 64'(m_state != 0));
            checkOutput("ptr_err", 64'(ptr_err), 64'(m_perr));
        end
    end

    // Write log of every BRAM address, used by the literal expectations.
    always @(negedge clk) begin
        if (m_valid && bram_en === 1'b1) addr_log.push_back(int'(bram_addr));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expectLiteral(input string name, input logic [63:0] act, input logic [63:0] exp);
        lit_name = name;
        lit_act  = act;
        lit_exp  = exp;
        lit_seq++;
        @(negedge clk);
        #1;
    endtask

    // Offers words until the requested number is accepted or the cycle budget runs out.
    task automatic applyStimulus(input int words, input int max_cycles, input bit must_finish);
        int got;
        int cyc;
        bit take;
        got = 0;
        cyc = 0;
        while (got < words && cyc < max_cycles) begin
            s_valid = 1'b1;
            s_data  = next_word * 32'h0100_0193 + 32'h1357_9BDF;
            take    = s_ready;
            tick();
            cyc++;
            if (take) begin
                got++;
                next_word = next_word + 1;
            end
        end
        s_valid = 1'b0;
        if (must_finish) expectLiteral("feed_accepted", 64'(got), 64'(words));
    endtask

    task automatic waitIdle(input int max_cycles);
        int c;
        c = 0;
        while (busy !== 1'b0 && c < max_cycles) begin
            tick();
            c++;
        end
        expectLiteral("idle_reached", 64'(busy), 64'd0);
    endtask

    task automatic pulseClear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    function automatic int logAt(input int idx);
        return (idx < addr_log.size()) ? addr_log[idx] : -1;
    endfunction

    initial begin : stimulus
        int base;
        int base2;
        $display("[TB] starting bram_packet_ring_writer bench");
        repeat (3) tick();
        expectLiteral("reset_s_ready", 64'(s_ready), 64'd0);
        expectLiteral("reset_bram_en", 64'(bram_en), 64'd0);
        expectLiteral("reset_fifo_count", 64'(fifo_count), 64'd0);
        expectLiteral("reset_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        tick();

        // Streaming: three packets in overwrite mode.
        overwrite_en = 1'b1;
        enable = 1'b1;
        tick();
        base = addr_log.size();
        applyStimulus(432, 1000, 1'b1);
        enable = 1'b0;
        waitIdle(200);
        expectLiteral("stream_writes", 64'(addr_log.size() - base), 64'd432);
        expectLiteral("stream_first_addr", 64'(logAt(base)), 64'd0);
        expectLiteral("stream_last_addr", 64'(logAt(base + 431)), 64'd1724);
        expectLiteral("stream_wr_ptr", 64'(wr_ptr), 64'd432);
        expectLiteral("stream_packets", 64'(packet_count), 64'd3);
        expectLiteral("stream_stalls", 64'(stall_cycles), 64'd0);

        // Wrap: 114 packets through a 113-packet ring.
        pulseClear();
        expectLiteral("clear_wr_ptr", 64'(wr_ptr), 64'd0);
        enable = 1'b1;
        tick();
        base = addr_log.size();
        applyStimulus(114 * PK, 17000, 1'b1);
        enable = 1'b0;
        waitIdle(300);
        expectLiteral("wrap_last_slot", 64'(logAt(base + 16271)), 64'd65084);
        expectLiteral("wrap_to_zero", 64'(logAt(base + 16272)), 64'd0);
        expectLiteral("wrap_wr_ptr", 64'(wr_ptr), 64'd144);
        expectLiteral("wrap_packets", 64'(packet_count), 64'd114);

        // Backpressure: read pointer at zero holds the writer one slot short of a full ring.
        pulseClear();
        overwrite_en = 1'b0;
        rd_ptr = '0;
        enable = 1'b1;
        tick();
        base = addr_log.size();
        applyStimulus(20000, 16271 + 256 + 60, 1'b0);
        expectLiteral("bp_writes", 64'(addr_log.size() - base), 64'd16271);
        expectLiteral("bp_last_addr", 64'(logAt(addr_log.size() - 1)), 64'd65080);
        expectLiteral("bp_model_wa", 64'(m_wa), 64'd16271);
        expectLiteral("bp_s_ready", 64'(s_ready), 64'd0);
        expectLiteral("bp_fifo_full", 64'(fifo_count), 64'd256);
        expectLiteral("bp_stalling", 64'(stall_cycles > 0), 64'd1);
        rd_ptr = PW'(288);
        base2 = addr_log.size();
        applyStimulus(20000, 600, 1'b0);
        expectLiteral("bp_resume_first", 64'(logAt(base2)), 64'd65084);
        expectLiteral("bp_resume_writes", 64'(addr_log.size() - base2), 64'd288);
        expectLiteral("bp_resume_last", 64'(logAt(addr_log.size() - 1)), 64'd1144);
        expectLiteral("bp_model_wa2", 64'(m_wa), 64'd287);
        enable = 1'b0;
        overwrite_en = 1'b1;
        waitIdle(1000);

        // Partial drain: second packet stops after 100 words and is rewound.
        pulseClear();
        enable = 1'b1;
        tick();
        base = addr_log.size();
        applyStimulus(244, 400, 1'b1);
        enable = 1'b0;
        waitIdle(100);
        expectLiteral("partial_writes", 64'(addr_log.size() - base), 64'd244);
        expectLiteral("partial_wr_ptr", 64'(wr_ptr), 64'd144);
        expectLiteral("partial_packets", 64'(packet_count), 64'd1);
        enable = 1'b1;
        tick();
        base = addr_log.size();
        applyStimulus(1, 10, 1'b1);
        repeat (3) tick();
        expectLiteral("partial_rewind_addr", 64'(logAt(base)), 64'd576);
        enable = 1'b0;
        waitIdle(100);

        // Errors and clear: out-of-ring read pointer blocks writing.
        pulseClear();
        overwrite_en = 1'b0;
        rd_ptr = PW'(16300);
        enable = 1'b1;
        tick();
        base = addr_log.size();
        applyStimulus(10, 20, 1'b1);
        repeat (3) tick();
        expectLiteral("err_no_writes", 64'(addr_log.size() - base), 64'd0);
        expectLiteral("err_ptr_err", 64'(ptr_err), 64'd1);
        expectLiteral("err_fifo_held", 64'(fifo_count), 64'd10);
        pulseClear();
        expectLiteral("err_clear_in_run", 64'(ptr_err), 64'd1);
        enable = 1'b0;
        rd_ptr = '0;
        waitIdle(100);
        expectLiteral("err_sticky_idle", 64'(ptr_err), 64'd1);
        pulseClear();
        expectLiteral("err_cleared", 64'(ptr_err), 64'd0);
        expectLiteral("err_clear_wr_ptr", 64'(wr_ptr), 64'd0);
        expectLiteral("err_clear_packets", 64'(packet_count), 64'd0);

        // Reset mid-packet with fifty words queued.
        rd_ptr = PW'(10);
        enable = 1'b1;
        tick();
        applyStimulus(59, 200, 1'b1);
        repeat (3) tick();
        expectLiteral("rst_pre_fifo", 64'(fifo_count), 64'd50);
        rst = 1'b1;
        tick();
        expectLiteral("rst_fifo_count", 64'(fifo_count), 64'd0);
        expectLiteral("rst_s_ready", 64'(s_ready), 64'd0);
        expectLiteral("rst_bram_en", 64'(bram_en), 64'd0);
        expectLiteral("rst_bram_we", 64'(bram_we), 64'd0);
        expectLiteral("rst_bram_addr", 64'(bram_addr), 64'd0);
        expectLiteral("rst_bram_din", 64'(bram_din), 64'd0);
        expectLiteral("rst_busy", 64'(busy), 64'd0);
        expectLiteral("rst_stall", 64'(stall_cycles), 64'd0);
        rst = 1'b0;
        enable = 1'b0;
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
